// File: rtl/fpu_status_pkg.sv
// rtl/fpu_status_pkg.sv - FPU status word field positions shared by core, debug and bus register
package fpu_status_pkg;

   localparam int STATUS_WIDTH = 16;

   localparam int BUSY_BIT = 15;
   localparam int C3_BIT   = 14;
   localparam int TOP_MSB  = 13;   // TOP: 3-bit register stack pointer
   localparam int TOP_LSB  = 11;
   localparam int C2_BIT   = 10;
   localparam int C1_BIT   = 9;
   localparam int C0_BIT   = 8;
   localparam int ES_BIT   = 7;    // error summary
   localparam int SF_BIT   = 6;    // stack fault
   localparam int EXC_MSB  = 5;    // exception flags, MSB..LSB = PE UE OE ZE DE IE
   localparam int EXC_LSB  = 0;

endpackage

// File: rtl/fpu_status_register.sv
// rtl/fpu_status_register.sv - read-only bus register exposing the live FPU status word
//   clk             : system clock, rising edge
//   reset           : asynchronous active-high reset (clears ack only)
//   cs              : chip select from bus decode
//   status_word_in  : live status word from the FPU core
//   data_m_data_out : read data, combinational copy of status_word_in
//   data_m_ack      : bus acknowledge, cs delayed by one clock
module fpu_status_register
   import fpu_status_pkg::*;
#(
   parameter int DATA_WIDTH = STATUS_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cs,
   input  logic [DATA_WIDTH-1:0] status_word_in,
   output logic [DATA_WIDTH-1:0] data_m_data_out,
   output logic                  data_m_ack
);

   // Read data is the live word itself: no cs gating and no reset, so the
   // bus always sees the current status even during reset.
   assign data_m_data_out = status_word_in;

   // Level-following acknowledge; writes are acknowledged and ignored.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_m_ack <= 1'b0;
      end else begin
         data_m_ack <= cs;
      end
   end

endmodule

// File: tb/tb_fpu_status_register.sv
// tb/tb_fpu_status_register.sv - scoreboard bench for fpu_status_register
`timescale 1ns/100ps
module tb_fpu_status_register;

   logic        clk = 1'b0;
   logic        reset;
   logic        cs;
   logic [15:0] status_word_in;
   logic [15:0] data_m_data_out;
   logic        data_m_ack;

   typedef struct {
      logic [15:0] data;
      logic        ack;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   bit   chk_req = 1'b0;
   int   total = 0;
   int   bad = 0;

   fpu_status_register #(.DATA_WIDTH(16)) dut (
      .clk             (clk),
      .reset           (reset),
      .cs              (cs),
      .status_word_in  (status_word_in),
      .data_m_data_out (data_m_data_out),
      .data_m_ack      (data_m_ack)
   );

   always #20 clk = ~clk;

   // Drive inputs, record what the outputs must show right now, then ask
   // the monitor to sample.
   task automatic apply(input logic r, input logic c, input logic [15:0] sw,
                        input logic ea, input string nm);
      exp_t e;
      reset          = r;
      cs             = c;
      status_word_in = sw;
      e.data = sw;
      e.ack  = ea;
      e.name = nm;
      exp_q.push_back(e);
      chk_req = ~chk_req;
      #2;
   endtask

   task automatic step(input logic r, input logic c, input logic [15:0] sw,
                       input logic ea, input string nm);
      @(posedge clk);
      #2;
      apply(r, c, sw, ea, nm);
   endtask

   // Monitor: samples 1ns after each request, well away from clock edges.
   initial begin
      exp_t e;
      forever begin
         @(chk_req);
         #1;
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL no_expectation: sample with empty scoreboard");
         end else begin
            e = exp_q.pop_front();
            total++;
            if (data_m_data_out !== e.data) begin
               bad++;
               $display("FAIL %s data: got %h want %h", e.name, data_m_data_out, e.data);
            end
            total++;
            if (data_m_ack !== e.ack) begin
               bad++;
               $display("FAIL %s ack: got %b want %b", e.name, data_m_ack, e.ack);
            end
         end
      end
   end

   initial begin
      reset = 1'b1;
      cs = 1'b0;
      status_word_in = 16'h0000;

      // 1: reset two cycles, release, combinational data
      step(1, 0, 16'h0000, 0, "rst_cyc1");
      step(1, 0, 16'h0000, 0, "rst_cyc2");
      step(0, 0, 16'h1234, 0, "pass_1234");
      apply(0, 0, 16'h5678, 0, "pass_5678");

      // 2: basic ack latency
      step(0, 0, 16'h5678, 0, "cs0_idle");
      step(0, 1, 16'h5678, 0, "cs1_no_ack_yet");
      step(0, 0, 16'h5678, 1, "ack_after_edge");
      step(0, 0, 16'h5678, 0, "ack_dropped");

      // 3: field patterns, all within one cycle
      step(0, 0, 16'h8000, 0, "busy");
      apply(0, 0, 16'h1800, 0, "top3");
      apply(0, 0, 16'h4700, 0, "cc_all");
      apply(0, 0, 16'h003F, 0, "exc_all");
      apply(0, 0, 16'hFFFF, 0, "all_ones");

      // 4: async reset mid-access
      step(0, 1, 16'h0000, 0, "acc_start");
      step(0, 1, 16'h0000, 1, "acc_ack");
      apply(1, 1, 16'h0000, 0, "async_rst");
      step(1, 1, 16'hABCD, 0, "rst_hold_cs1");

      // 5: release reset with cs high
      step(0, 1, 16'hABCD, 0, "rel_no_edge");
      step(0, 1, 16'hABCD, 1, "rel_ack");
      step(0, 0, 16'h0000, 1, "cs_fall");
      step(0, 0, 16'h0000, 0, "ack_fall");

      // 6: cs held 5 cycles, then toggling
      step(0, 1, 16'h0001, 0, "hold_c1");
      step(0, 1, 16'h0002, 1, "hold_c2");
      step(0, 1, 16'h0004, 1, "hold_c3");
      step(0, 1, 16'h0008, 1, "hold_c4");
      step(0, 1, 16'h0010, 1, "hold_c5");
      step(0, 0, 16'h0020, 1, "hold_tail");
      step(0, 0, 16'h0040, 0, "hold_end");
      step(0, 1, 16'h0080, 0, "tog_1");
      step(0, 0, 16'h0100, 1, "tog_2");
      step(0, 1, 16'h0200, 0, "tog_3");
      step(0, 0, 16'h0400, 1, "tog_4");
      step(0, 0, 16'h0800, 0, "tog_5");

      // drain the scoreboard with a bounded wait
      begin
         int waited = 0;
         while (exp_q.size() != 0 && waited < 100) begin
            #1;
            waited++;
         end
         if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
         end
      end
      #5;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fpu_status_register.md
Name: fpu_status_register

Overview:
- Read-only I/O register that exposes the FPU status word to the CPU data bus.
- Sits between the FPU core, which drives the live status word, and the data-memory/I-O bus decode, which drives chip select.
- Data is a pure combinational passthrough of the core's status word.
- The bus acknowledge is a registered copy of chip select.

Parameters:
- DATA_WIDTH, 16, width of the status word and the bus data output. Only 16 is required to be supported.

Ports:
- clk  input  1  system clock; all sequential logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- cs  input  1  chip select from bus decode; high means this register is being accessed.
- status_word_in  input  DATA_WIDTH  live FPU status word from the FPU core.
- data_m_data_out  output  DATA_WIDTH  read data to the bus.
- data_m_ack  output  1  bus acknowledge.

Behaviour:
- One clock; reset is asynchronous and active-high.
- data_m_data_out = status_word_in, combinational, zero latency.
  - Not gated by cs, not affected by reset, no register stage.
  - All bits pass unmodified; the register performs no interpretation of bit fields.
- data_m_ack is a flip-flop.
  - Reset value 0.
  - On reset assertion it clears to 0 immediately, without waiting for a clock edge, and holds 0 while reset is high.
  - While reset is low, each rising clk edge loads data_m_ack <= cs.
  - Latency from cs to ack is one cycle.
  - If cs is held high for N cycles, ack stays high for N cycles, delayed by one cycle. It is level-following, not a single pulse.
  - Ack drops one cycle after cs falls.
- The register is read-only: there is no write-data or write-enable input, so bus writes to this address have no effect beyond being acknowledged.
- Simultaneous reset and cs=1: reset wins, ack = 0.
- cs toggling every cycle: ack follows with a one-cycle delay. There is no minimum pulse width and no stretching.
- No internal state other than the ack flop. No X propagation from status_word_in into ack.

Decomposition:
- Shared package fpu_status_pkg holds status-word field constants:
  - BUSY_BIT=15, C3_BIT=14, TOP_MSB=13, TOP_LSB=11, C2_BIT=10, C1_BIT=9, C0_BIT=8
  - ES_BIT=7, SF_BIT=6, EXC_MSB=5, EXC_LSB=0 (IE, DE, ZE, OE, UE, PE)
  - STATUS_WIDTH=16
- These constants are consumed by the FPU core and debug logic. This block does not decode fields.
- No sub-module; a single flat module.

Test Plan:
1. Reset asserted for 2 cycles, then released, cs=0 -> data_m_ack=0. With status_word_in=0x1234 then 0x5678, data_m_data_out equals each value within the same delta, with no clock edge needed.
2. cs=0 across one clock -> ack=0. Set cs=1, one rising edge -> ack=1. Set cs=0, one rising edge -> ack=0.
3. Field patterns 0x8000 (busy), 0x1800 (TOP=3), 0x4700 (C3..C0 set), 0x003F (all exception flags), 0xFFFF -> data_m_data_out equals each input exactly, combinationally.
4. cs=1, one edge -> ack=1. Assert reset mid-access -> ack=0 immediately, before the next edge, and stays 0 at the following edge even with cs=1.
5. While reset is high, status_word_in=0xABCD -> data_m_data_out=0xABCD. Release reset with cs=1 -> ack=1 after the first rising edge.
6. cs held high 5 cycles -> ack high for exactly 5 cycles, starting one cycle after cs rose. cs toggled every cycle -> ack toggles every cycle, delayed by one.
